// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
// - fetch_state_e : fetch FSM states (IDLE, REQ, DROP)
// - fetch_entry_t : one prefetch buffer entry {pc, instr}
// - DEFAULT_RESET_PC / DEFAULT_FIFO_DEPTH : default parameter values
// - align_word    : forces an address onto a 32-bit word boundary
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int          DEFAULT_FIFO_DEPTH = 2;

  // Branch targets may carry junk in the two low bits; fetch is word based.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit and its neighbours.
// - imem_*     : instruction memory read handshake (req/ack, addr, rdata)
// - instr_*    : decoded-side valid/ready stream {instrCode, instr_pc}
// - redirect*  : branch/jump redirect pulse and target from execute
// Modport master is the fetch unit; slave is the memory/decode/execute side.
interface instr_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instrCode;
  logic [31:0] instr_pc;

  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instrCode, instr_pc,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instrCode, instr_pc,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Small synchronous prefetch FIFO of fetch_entry_t.
// - clk, reset_n  : clock and synchronous active-low reset
// - push/push_entry : write one entry at the tail
// - pop           : drop the head entry
// - flush         : empty the FIFO, dominant over push and pop
// - head_entry/head_valid : combinational view of the head (zero when empty)
// - count         : number of stored entries (0..DEPTH)
module instr_fetch_unit_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head_entry,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guard against overfilling or popping empty so the pointers can never
  // drift apart from count, even if a caller misbehaves.
  assign do_push    = push && (int'(count) < DEPTH);
  assign do_pop     = pop && (count != '0);
  assign head_valid = (count != '0);
  assign head_entry = head_valid ? storage[rd_ptr] : '0;

  // Entry storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      storage[wr_ptr] <= push_entry;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end of the single-issue RV32I core.
// - clk, reset_n : core clock, synchronous active-low reset
// - bus (master) : imem req/ack read port, decode valid/ready stream,
//                  redirect pulse + target from execute
// Owns the fetch PC, keeps at most one memory read outstanding, buffers
// returned words in a prefetch FIFO and discards wrong-path fetches on a
// redirect (a read already in flight is finished in DROP and thrown away).
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset_n,
  instr_fetch_unit_if.master bus
);

  fetch_state_e                 state;
  logic [31:0]                  fetch_pc;
  logic [31:0]                  drop_target;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         push;
  logic                         pop;
  logic                         flush;
  logic                         head_valid;
  logic                         space_now;
  logic                         space_after_push;
  fetch_entry_t                 push_entry;
  fetch_entry_t                 head_entry;

  // Only REQ results are kept, and a redirect in the same cycle wins.
  assign push       = (state == REQ) && bus.imem_ack && !bus.redirect;
  assign pop        = head_valid && bus.instr_ready;
  assign flush      = bus.redirect;
  assign push_entry = '{pc: fetch_pc, instr: bus.imem_rdata};

  // Occupancy seen after this cycle's push/pop; a new request is issued
  // only when its result is guaranteed a free slot.
  assign space_now        = int'(fifo_count) < FIFO_DEPTH;
  assign space_after_push = (int'(fifo_count) + 1 - int'(pop)) < FIFO_DEPTH;

  // fetch_pc only moves when a read completes, so during DROP it still
  // holds the stale address of the read being finished.
  assign bus.imem_req    = (state == REQ) || (state == DROP);
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = head_valid;
  assign bus.instrCode   = head_entry.instr;
  assign bus.instr_pc    = head_entry.pc;

  instr_fetch_unit_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .head_entry (head_entry),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  // Fetch FSM and PC. A redirect overrides everything; if a read is still
  // waiting for its ack the target is parked in drop_target until the stale
  // read completes, so the memory never sees two outstanding requests.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      drop_target <= '0;
    end else if (bus.redirect) begin
      case (state)
        IDLE: begin
          fetch_pc <= align_word(bus.redirect_pc);
          state    <= REQ;
        end
        REQ, DROP: begin
          if (bus.imem_ack) begin
            fetch_pc <= align_word(bus.redirect_pc);
            state    <= REQ;
          end else begin
            drop_target <= align_word(bus.redirect_pc);
            state       <= DROP;
          end
        end
        default: state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (space_now) begin
            state <= REQ;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            fetch_pc <= fetch_pc + 32'd4;
            state    <= space_after_push ? REQ : IDLE;
          end
        end
        DROP: begin
          if (bus.imem_ack) begin
            fetch_pc <= drop_target;
            state    <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// Drives a behavioural instruction memory (configurable ack latency), the
// decode ready and redirect pulses. A scoreboard queue holds the program-
// order PCs decode should see; it is rebuilt whenever a reset or redirect is
// issued, and a monitor pops it on every accepted instruction.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;

  logic clk;
  logic reset_n;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int assertCount = 0;
  int failCount   = 0;

  bit          rstDrive;
  int          readyMode;
  int          latMode;
  bit          randomMode;
  bit          redirNow;
  logic [31:0] redirTarget;

  int          waitCnt;
  bit          lastReq;
  bit          lastAck;
  bit          lastRst;
  logic [31:0] lastAddr;
  int          ackSeen = 0;

  logic [31:0] expQ [$];
  logic [31:0] expTail;
  logic [31:0] expPc;
  logic        prevRstN  = 1'b0;
  logic        prevRedir = 1'b0;
  int          stallCnt  = 0;

  // Free-running core clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {addr[15:0], ~addr[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual,
                           input logic expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Program order restarts at the given address after a reset or redirect.
  task automatic refillExpected(input logic [31:0] start);
    expQ.delete();
    expTail = start & 32'hFFFF_FFFC;
    while (expQ.size() < 8) begin
      expQ.push_back(expTail);
      expTail += 32'd4;
    end
  endtask

  // One clock cycle of stimulus: checks the request stayed put while a read
  // was outstanding, then drives reset, ready, redirect and the memory reply.
  task automatic applyStimulus();
    bit pending;
    @(posedge clk);
    #1;
    pending = lastReq && !lastAck && lastRst;
    if (pending) begin
      checkFlag("req_hold", bus.imem_req, 1'b1);
      checkOutput("addr_hold", bus.imem_addr, lastAddr);
    end
    if (randomMode) rstDrive = ($urandom_range(0, 999) < 3);
    reset_n = !rstDrive;
    case (readyMode)
      0:       bus.instr_ready = 1'b0;
      1:       bus.instr_ready = 1'b1;
      default: bus.instr_ready = ($urandom_range(0, 99) < 70);
    endcase
    if (randomMode && !rstDrive && ($urandom_range(0, 99) < 4)) begin
      redirNow    = 1'b1;
      redirTarget = $urandom;
    end
    bus.redirect    = redirNow && !rstDrive;
    bus.redirect_pc = redirNow ? redirTarget : $urandom;
    redirNow        = 1'b0;
    if (bus.imem_req) begin
      if (!pending) waitCnt = (latMode < 0) ? int'($urandom_range(0, 3)) : latMode;
      if (waitCnt == 0) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = memWord(bus.imem_addr);
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        waitCnt--;
      end
    end else begin
      bus.imem_ack   = randomMode ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.imem_rdata = $urandom;
    end
    lastReq  = bus.imem_req;
    lastAck  = bus.imem_ack;
    lastAddr = bus.imem_addr;
    lastRst  = reset_n;
    @(negedge clk);
  endtask

  task automatic resetDut();
    rstDrive = 1'b1;
    repeat (2) applyStimulus();
    rstDrive = 1'b0;
    applyStimulus();
  endtask

  task automatic waitValid(input int budget);
    for (int k = 0; k < budget && !bus.instr_valid; k++) applyStimulus();
  endtask

  // Monitor: reset and flush rules, alignment, ack counting, the scoreboard
  // comparison of every accepted instruction, and a progress watchdog.
  always @(negedge clk) begin
    if (!prevRstN) begin
      checkFlag("rst_req", bus.imem_req, 1'b0);
      checkFlag("rst_valid", bus.instr_valid, 1'b0);
      checkOutput("rst_code", bus.instrCode, 32'h0);
      checkOutput("rst_pc", bus.instr_pc, 32'h0);
    end else if (prevRedir) begin
      checkFlag("redir_flush_valid", bus.instr_valid, 1'b0);
    end
    if (bus.imem_req) checkOutput("addr_align", bus.imem_addr & 32'h3, 32'h0);
    if (bus.imem_req && bus.imem_ack && reset_n) ackSeen++;
    if (!reset_n) begin
      refillExpected(RESET_PC);
    end else if (bus.redirect) begin
      refillExpected(bus.redirect_pc);
    end else if (bus.instr_valid && bus.instr_ready) begin
      expPc = expQ.pop_front();
      checkOutput("sb_pc", bus.instr_pc, expPc);
      checkOutput("sb_instr", bus.instrCode, memWord(expPc));
      while (expQ.size() < 8) begin
        expQ.push_back(expTail);
        expTail += 32'd4;
      end
    end
    if (!reset_n || bus.redirect || bus.instr_valid) stallCnt = 0;
    else stallCnt++;
    if (stallCnt > 40) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL fetch_progress: no instr_valid for %0d cycles, required at most 40", stallCnt);
      stallCnt = 0;
    end
    prevRstN  = reset_n;
    prevRedir = bus.redirect && reset_n;
  end

  // Directed scenarios first, then a long randomized run.
  initial begin
    int snap;
    reset_n         = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    rstDrive = 1'b1; readyMode = 1; latMode = 0; randomMode = 1'b0;
    redirNow = 1'b0; redirTarget = '0; waitCnt = 0;
    lastReq = 1'b0; lastAck = 1'b0; lastRst = 1'b0; lastAddr = '0;

    $display("[TB] reset and zero-wait streaming");
    repeat (3) applyStimulus();
    checkFlag("reset_req", bus.imem_req, 1'b0);
    checkFlag("reset_valid", bus.instr_valid, 1'b0);
    rstDrive = 1'b0;
    applyStimulus();
    checkFlag("release_req_idle", bus.imem_req, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkFlag("zw_req", bus.imem_req, 1'b1);
      checkOutput("zw_addr", bus.imem_addr, 32'(4 * i));
      if (i == 0) begin
        checkFlag("zw_first_valid", bus.instr_valid, 1'b0);
      end else begin
        checkFlag("zw_valid", bus.instr_valid, 1'b1);
        checkOutput("zw_pc", bus.instr_pc, 32'(4 * (i - 1)));
      end
    end

    $display("[TB] decode backpressure");
    readyMode = 0; latMode = 0;
    resetDut();
    snap = ackSeen;
    repeat (6) applyStimulus();
    checkOutput("bp_acks", 32'(ackSeen - snap), 32'd2);
    checkFlag("bp_req_idle", bus.imem_req, 1'b0);
    checkFlag("bp_valid", bus.instr_valid, 1'b1);
    readyMode = 1;
    applyStimulus();
    checkOutput("bp_pc0", bus.instr_pc, 32'h0);
    applyStimulus();
    checkFlag("bp_valid1", bus.instr_valid, 1'b1);
    checkOutput("bp_pc1", bus.instr_pc, 32'h4);

    $display("[TB] delayed ack");
    readyMode = 1; latMode = 3;
    resetDut();
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkFlag("dl_req", bus.imem_req, 1'b1);
      checkOutput("dl_addr", bus.imem_addr, 32'h0);
      checkFlag("dl_valid", bus.instr_valid, 1'b0);
    end
    applyStimulus();
    checkFlag("dl_valid_after", bus.instr_valid, 1'b1);
    checkOutput("dl_pc", bus.instr_pc, 32'h0);

    $display("[TB] redirect while waiting for ack");
    readyMode = 0; latMode = 2;
    resetDut();
    repeat (3) applyStimulus();
    redirNow = 1'b1; redirTarget = 32'h0000_0100;
    applyStimulus();
    checkFlag("e_valid_pre", bus.instr_valid, 1'b1);
    checkOutput("e_addr_pre", bus.imem_addr, 32'h4);
    readyMode = 1;
    applyStimulus();
    checkFlag("e_flush_valid", bus.instr_valid, 1'b0);
    checkFlag("e_drop_req", bus.imem_req, 1'b1);
    checkOutput("e_drop_addr", bus.imem_addr, 32'h4);
    applyStimulus();
    checkFlag("e_drop_valid", bus.instr_valid, 1'b0);
    applyStimulus();
    checkOutput("e_new_addr", bus.imem_addr, 32'h0000_0100);
    waitValid(20);
    checkFlag("e_new_valid", bus.instr_valid, 1'b1);
    checkOutput("e_first_pc", bus.instr_pc, 32'h0000_0100);
    checkOutput("e_first_instr", bus.instrCode, memWord(32'h0000_0100));

    $display("[TB] back-to-back redirects, alignment and wrap");
    readyMode = 1; latMode = 4;
    resetDut();
    applyStimulus();
    redirNow = 1'b1; redirTarget = 32'h0000_0200;
    applyStimulus();
    redirNow = 1'b1; redirTarget = 32'h0000_0300;
    applyStimulus();
    checkFlag("f_drop_req", bus.imem_req, 1'b1);
    checkOutput("f_drop_addr", bus.imem_addr, 32'h0);
    latMode = 0;
    repeat (2) applyStimulus();
    applyStimulus();
    checkOutput("f_new_addr", bus.imem_addr, 32'h0000_0300);
    applyStimulus();
    checkFlag("f_valid", bus.instr_valid, 1'b1);
    checkOutput("f_pc", bus.instr_pc, 32'h0000_0300);
    repeat (3) applyStimulus();
    redirNow = 1'b1; redirTarget = 32'h0000_0103;
    applyStimulus();
    applyStimulus();
    checkOutput("f_align_addr", bus.imem_addr, 32'h0000_0100);
    repeat (2) applyStimulus();
    redirNow = 1'b1; redirTarget = 32'hFFFF_FFF8;
    applyStimulus();
    applyStimulus();
    checkOutput("wrap_addr0", bus.imem_addr, 32'hFFFF_FFF8);
    applyStimulus();
    checkOutput("wrap_addr1", bus.imem_addr, 32'hFFFF_FFFC);
    applyStimulus();
    checkOutput("wrap_addr2", bus.imem_addr, 32'h0000_0000);
    repeat (4) applyStimulus();

    $display("[TB] reset during an outstanding read");
    readyMode = 0; latMode = 3;
    resetDut();
    repeat (5) applyStimulus();
    checkFlag("g_valid_pre", bus.instr_valid, 1'b1);
    checkFlag("g_req_pre", bus.imem_req, 1'b1);
    rstDrive = 1'b1;
    applyStimulus();
    rstDrive = 1'b0;
    applyStimulus();
    checkFlag("g_req", bus.imem_req, 1'b0);
    checkFlag("g_valid", bus.instr_valid, 1'b0);
    applyStimulus();
    checkFlag("g_restart_req", bus.imem_req, 1'b1);
    checkOutput("g_restart_addr", bus.imem_addr, RESET_PC);

    $display("[TB] randomized traffic");
    readyMode = 2; latMode = -1; randomMode = 1'b1;
    repeat (3000) applyStimulus();
    randomMode = 1'b0; rstDrive = 1'b0; readyMode = 1; latMode = 0;
    repeat (10) applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
